inst_loader_rom: RTL and testbench
==================================

# inst_loader_rom

Instruction memory with a byte-serial program loader, sitting directly upstream of `if_pc`/`IF_ID`: it supplies the instruction word on `rom_data_o` for the address driven by the PC. While a program is being loaded it holds the CPU core in reset through `cpu_rst_o`. After the final word is written it releases the core, which then fetches from address 0.

## Interface
- `DEPTH`, 256: instruction words stored; power of two, ≤ 65536
- `INST_W`, 16: instruction width (`InstBus`)
- `ADDR_W`, 16: fetch address width (`InstAddrBus`)
- `clk  in  1  system clock, rising edge`
- `rst  in  1  reset; one clock; reset is asynchronous and active-high`
- `ld_start_i  in  1  single-cycle pulse: begin a new load`
- `ld_valid_i  in  1  ld_byte_i carries a byte`
- `ld_byte_i  in  8  load byte`
- `ld_ready_o  out  1  loader accepts a byte this cycle`
- `ld_done_o  out  1  program loaded, core running`
- `err_o  out  1  length header exceeded DEPTH; sticky until next ld_start_i`
- `cpu_rst_o  out  1  active-high reset to the core`
- `word_cnt_o  out  ADDR_W  words written in the current load`
- `rom_ce_i  in  1  fetch enable from the PC stage`
- `rom_addr_i  in  ADDR_W  fetch address (PC)`
- `rom_data_o  out  INST_W  instruction word`

## Operation
- States: IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, RUN.
- Load stream format: a big-endian 16-bit length N, then N instruction words, each big-endian (high byte first).
- A byte is accepted on a clock edge when `ld_valid_i && ld_ready_o`.
- `ld_ready_o` = 1 in the HDR_* and DAT_* states and 0 otherwise.
- IDLE: on `ld_start_i`, clear `word_cnt_o` and `err_o`, then go to HDR_HI.
- HDR_HI → HDR_LO: latch the high byte of N.
- HDR_LO: latch the low byte of N, then branch:
  - N = 0 → RUN.
  - N > DEPTH → set `err_o`, go to IDLE.
  - Otherwise → DAT_HI.
- DAT_HI → DAT_LO: latch the high byte of the current word.
- DAT_LO: on the accepted low byte, write `{hi, lo}` to `mem[word_cnt]` and increment `word_cnt`. If the new count equals N, go to RUN; otherwise go to DAT_HI.
- RUN: `ld_start_i` goes to HDR_HI and clears `word_cnt_o`.
- `ld_start_i` in any HDR_* or DAT_* state restarts at HDR_HI with `word_cnt_o` cleared. Words already written stay in the array but fall outside the readable range.
- Simultaneous `ld_start_i` and an accepted byte: start wins and the byte is dropped.
- Fetch path (combinational) returns `mem[rom_addr_i]` only when all of the following hold:
  - state is RUN,
  - `rom_ce_i` = 1,
  - `rom_addr_i < word_cnt`.
- In every other case the fetch path returns `ZeroWord`, which is a NOP.
- Address bits above log2(DEPTH) are not ignored: any address ≥ `word_cnt` returns `ZeroWord`, so there is no wrap-around.
- `cpu_rst_o` = 1 whenever state ≠ RUN.
- `ld_done_o` = 1 exactly when state = RUN.
- The array is not cleared by `rst`; stale contents are masked by the `word_cnt` check.

## Timing
- Values during `rst`:
  - state = IDLE
  - `cpu_rst_o` = 1
  - `ld_done_o` = 0
  - `ld_ready_o` = 0
  - `err_o` = 0
  - `word_cnt_o` = 0
  - `rom_data_o` = `ZeroWord`
- Fetch latency is zero: `rom_data_o` is combinational from `rom_addr_i`, so `IF_ID` captures PC and instruction on the same edge.
- Array write takes effect at the edge that accepts the low byte. The word is readable from the first cycle of RUN.
- `cpu_rst_o` falls and `ld_done_o` rises in the cycle after the edge that accepts the final byte. Both are registered from state and glitch-free.
- Throughput: one byte per cycle when `ld_valid_i` is held high. A load of N words takes 2 + 2N accepting cycles.
- `rst` asserted mid-load returns to IDLE asynchronously and clears `word_cnt_o`, so the partial program is not fetchable.

## Structure
- Shared definitions go in `defines.sv`:
  - `RstEnable`, `ZeroWord`, `InstBus`, `InstAddrBus` (existing)
  - new enum `loader_state_t` with the six states
  - new constant `LdLenBytes` = 2
- Sub-module `inst_ram`: DEPTH × INST_W, one synchronous write port, one asynchronous read port. Control FSM and address gating live in `inst_loader_rom`.

## Test plan
- Reset, then `rom_ce_i`=1, `rom_addr_i`=0 → `rom_data_o`=0x0000, `cpu_rst_o`=1, `ld_ready_o`=0.
- Start pulse, then bytes 00 02 34 43 12 AB → next cycle `ld_done_o`=1, `cpu_rst_o`=0, `word_cnt_o`=2. Reads: addr 0 → 0x3443, addr 1 → 0x12AB, addr 2 → 0x0000.
- Start pulse, then header 01 01 with DEPTH=256 → `err_o`=1, state IDLE, `cpu_rst_o`=1. The next start pulse clears `err_o`.
- During the test-2 load, pulse `ld_start_i` after 3 data bytes, then send 00 01 AA 55 → `word_cnt_o`=1, addr 0 → 0xAA55, addr 1 → 0x0000.
- Gapped `ld_valid_i` (every third cycle), plus `ld_start_i` coincident with a valid byte → the gap bytes are ignored and the coincident byte is dropped, so only the post-start stream is loaded.
- In RUN, assert `rst` asynchronously mid-cycle → `cpu_rst_o`=1 and `rom_data_o`=0x0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_loader_rom_pkg.sv
// inst_loader_rom_pkg: shared widths, constants and loader state type
package inst_loader_rom_pkg;
   localparam logic RstEnable = 1'b1;
   localparam int InstBus = 16;
   localparam int InstAddrBus = 16;
   localparam logic [InstBus-1:0] ZeroWord = '0;
   localparam int LdLenBytes = 2;
   typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, RUN} loader_state_t;
endpackage

// File: rtl/inst_ram.sv
// inst_ram: instruction array with one synchronous write port and one asynchronous read port
module inst_ram #(
   parameter int DEPTH = 256,
   parameter int INST_W = 16,
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [INST_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [INST_W-1:0] o_rdata
);
   logic [INST_W-1:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_loader_rom.sv
// inst_loader_rom: byte-serial program loader and gated zero-latency instruction fetch port
module inst_loader_rom
   import inst_loader_rom_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int INST_W = InstBus,
   parameter int ADDR_W = InstAddrBus
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_start_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   output logic              ld_ready_o,
   output logic              ld_done_o,
   output logic              err_o,
   output logic              cpu_rst_o,
   output logic [ADDR_W-1:0] word_cnt_o,
   input  logic              rom_ce_i,
   input  logic [ADDR_W-1:0] rom_addr_i,
   output logic [INST_W-1:0] rom_data_o
);
   localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   loader_state_t r_state, w_nxt;
   logic [LdLenBytes*8-1:0] r_len, w_len;
   logic [7:0] r_hi;
   logic [ADDR_W-1:0] r_cnt;
   logic r_err, r_run, w_ready, w_acc, w_we, w_last, w_big;
   logic [INST_W-1:0] w_rd;
   assign w_ready = r_state inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO};
   assign w_acc = ld_valid_i && w_ready && !ld_start_i;
   assign w_len = {r_len[15:8], ld_byte_i};
   assign w_big = 32'(w_len) > DEPTH;
   assign w_last = (r_cnt + 1'b1) == ADDR_W'(r_len);
   assign w_we = w_acc && r_state == DAT_LO;
   always_comb begin
      w_nxt = r_state;
      if (ld_start_i) w_nxt = HDR_HI;
      else if (w_acc)
         case (r_state)
            HDR_HI:  w_nxt = HDR_LO;
            HDR_LO:  w_nxt = w_len == '0 ? RUN : (w_big ? IDLE : DAT_HI);
            DAT_HI:  w_nxt = DAT_LO;
            DAT_LO:  w_nxt = w_last ? RUN : DAT_HI;
            default: w_nxt = r_state;
         endcase
   end
   // r_run is registered from the next state so cpu_rst_o/ld_done_o never glitch on state decode
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_run <= 1'b0;
         r_len <= '0;
         r_hi <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_run <= w_nxt == RUN;
         if (ld_start_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (w_acc) begin
            if (r_state == HDR_HI) r_len <= {ld_byte_i, 8'h00};
            if (r_state == HDR_LO) begin
               r_len <= w_len;
               r_err <= w_big;
            end
            if (r_state == DAT_HI) r_hi <= ld_byte_i;
            if (w_we) r_cnt <= r_cnt + 1'b1;
         end
      end
   inst_ram #(.DEPTH(DEPTH), .INST_W(INST_W), .AW(MW)) u_ram (
      .clk(clk),
      .i_we(w_we),
      .i_waddr(r_cnt[MW-1:0]),
      .i_wdata(INST_W'({r_hi, ld_byte_i})),
      .i_raddr(rom_addr_i[MW-1:0]),
      .o_rdata(w_rd)
   );
   assign rom_data_o = (r_run && rom_ce_i && rom_addr_i < r_cnt) ? w_rd : INST_W'(ZeroWord);
   assign cpu_rst_o = r_run ? !RstEnable : RstEnable;
   assign ld_done_o = r_run;
   assign ld_ready_o = w_ready;
   assign err_o = r_err;
   assign word_cnt_o = r_cnt;
endmodule

// File: tb/tb_inst_loader_rom.sv
// tb_inst_loader_rom: randomized load/fetch scenarios checked against a program-level model
module tb_inst_loader_rom;
   localparam int DEPTH = 256;
   logic clk = 0, rst = 1, ld_start_i = 0, ld_valid_i = 0, rom_ce_i = 0;
   logic [7:0] ld_byte_i = 0;
   logic [15:0] rom_addr_i = 0;
   logic ld_ready_o, ld_done_o, err_o, cpu_rst_o;
   logic [15:0] word_cnt_o, rom_data_o;
   int n_cmp = 0, n_bad = 0;
   logic [15:0] m_mem [DEPTH];
   int m_cnt = 0;
   bit m_run = 0;
   logic [15:0] prog [$];
   always #5 clk = ~clk;
   inst_loader_rom #(.DEPTH(DEPTH), .INST_W(16), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i),
      .ld_byte_i(ld_byte_i), .ld_ready_o(ld_ready_o), .ld_done_o(ld_done_o),
      .err_o(err_o), .cpu_rst_o(cpu_rst_o), .word_cnt_o(word_cnt_o),
      .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_start();
      ld_start_i = 1;
      ld_valid_i = 0;
      step();
      ld_start_i = 0;
   endtask
   task automatic send_byte(input logic [7:0] b, input bit gap);
      if (gap) repeat (2) begin
         ld_valid_i = 0;
         ld_byte_i = 8'($urandom);
         step();
      end
      ld_valid_i = 1;
      ld_byte_i = b;
      step();
      ld_valid_i = 0;
   endtask
   task automatic send_load(input int n, input bit gap);
      logic [15:0] w;
      prog.delete();
      pulse_start();
      send_byte(8'(n >> 8), gap);
      send_byte(8'(n), gap);
      if (n > DEPTH) begin
         m_cnt = 0;
         m_run = 0;
      end else begin
         for (int i = 0; i < n; i++) begin
            w = 16'($urandom_range(1, 65535));
            prog.push_back(w);
            send_byte(w[15:8], gap);
            send_byte(w[7:0], gap);
         end
         for (int i = 0; i < n; i++) m_mem[i] = prog[i];
         m_cnt = n;
         m_run = 1;
      end
   endtask
   task automatic test_reset();
      rst = 1;
      rom_ce_i = 1;
      rom_addr_i = 0;
      repeat (2) step();
      n_cmp++; if (cpu_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst_o); end
      n_cmp++; if (ld_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", ld_done_o); end
      n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ld_ready_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_o); end
      n_cmp++; if (word_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", word_cnt_o); end
      n_cmp++; if (rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL reset_data got %h want 0000", rom_data_o); end
      rst = 0;
      step();
      n_cmp++; if (cpu_rst_o !== 1'b1 || ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset got cpu_rst=%b ready=%b want 1 0", cpu_rst_o, ld_ready_o); end
   endtask
   task automatic test_basic();
      logic [7:0] bytes [6] = '{8'h00, 8'h02, 8'h34, 8'h43, 8'h12, 8'hAB};
      pulse_start();
      n_cmp++; if (ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b want 1", ld_ready_o); end
      for (int i = 0; i < 5; i++) send_byte(bytes[i], 0);
      n_cmp++; if (cpu_rst_o !== 1'b1 || ld_done_o !== 1'b0) begin n_bad++; $display("FAIL basic_before_last got cpu_rst=%b done=%b want 1 0", cpu_rst_o, ld_done_o); end
      send_byte(bytes[5], 0);
      m_mem[0] = 16'h3443;
      m_mem[1] = 16'h12AB;
      m_cnt = 2;
      m_run = 1;
      n_cmp++; if (ld_done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin n_bad++; $display("FAIL basic_done got done=%b cpu_rst=%b want 1 0", ld_done_o, cpu_rst_o); end
      n_cmp++; if (word_cnt_o !== 16'(m_cnt)) begin n_bad++; $display("FAIL basic_cnt got %0d want %0d", word_cnt_o, m_cnt); end
      rom_ce_i = 1;
      for (int a = 0; a < 3; a++) begin
         logic [15:0] exp;
         rom_addr_i = 16'(a);
         #1;
         exp = a < m_cnt ? m_mem[a] : 16'h0000;
         n_cmp++; if (rom_data_o !== exp) begin n_bad++; $display("FAIL basic_read[%0d] got %h want %h", a, rom_data_o, exp); end
      end
      rom_ce_i = 0;
      rom_addr_i = 0;
      #1;
      n_cmp++; if (rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL basic_ce_off got %h want 0000", rom_data_o); end
      rom_ce_i = 1;
   endtask
   task automatic test_err();
      send_load(16'h0101, 0);
      rom_addr_i = 0;
      #1;
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err_o); end
      n_cmp++; if (cpu_rst_o !== 1'b1 || ld_ready_o !== 1'b0 || ld_done_o !== 1'b0) begin n_bad++; $display("FAIL err_idle got cpu_rst=%b ready=%b done=%b want 1 0 0", cpu_rst_o, ld_ready_o, ld_done_o); end
      n_cmp++; if (rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL err_data got %h want 0000", rom_data_o); end
      step();
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err_o); end
      pulse_start();
      n_cmp++; if (err_o !== 1'b0 || ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL err_clear got err=%b ready=%b want 0 1", err_o, ld_ready_o); end
   endtask
   task automatic test_restart();
      logic [7:0] first [5] = '{8'h00, 8'h02, 8'h34, 8'h43, 8'h12};
      logic [7:0] second [4] = '{8'h00, 8'h01, 8'hAA, 8'h55};
      pulse_start();
      foreach (first[i]) send_byte(first[i], 0);
      pulse_start();
      foreach (second[i]) send_byte(second[i], 0);
      m_mem[0] = 16'hAA55;
      m_cnt = 1;
      n_cmp++; if (word_cnt_o !== 16'd1 || ld_done_o !== 1'b1) begin n_bad++; $display("FAIL restart_cnt got cnt=%0d done=%b want 1 1", word_cnt_o, ld_done_o); end
      rom_addr_i = 0;
      #1;
      n_cmp++; if (rom_data_o !== m_mem[0]) begin n_bad++; $display("FAIL restart_read0 got %h want %h", rom_data_o, m_mem[0]); end
      rom_addr_i = 1;
      #1;
      n_cmp++; if (rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL restart_read1 got %h want 0000", rom_data_o); end
   endtask
   task automatic test_gapped();
      logic [7:0] pre [4] = '{8'h00, 8'h03, 8'h11, 8'h22};
      logic [7:0] post [4] = '{8'h00, 8'h01, 8'hBE, 8'hEF};
      pulse_start();
      foreach (pre[i]) send_byte(pre[i], 1);
      ld_start_i = 1;
      ld_valid_i = 1;
      ld_byte_i = 8'h77;
      step();
      ld_start_i = 0;
      ld_valid_i = 0;
      foreach (post[i]) send_byte(post[i], 1);
      m_mem[0] = 16'hBEEF;
      m_cnt = 1;
      n_cmp++; if (err_o !== 1'b0 || ld_done_o !== 1'b1) begin n_bad++; $display("FAIL gapped_state got err=%b done=%b want 0 1", err_o, ld_done_o); end
      n_cmp++; if (word_cnt_o !== 16'd1) begin n_bad++; $display("FAIL gapped_cnt got %0d want 1", word_cnt_o); end
      rom_addr_i = 0;
      #1;
      n_cmp++; if (rom_data_o !== m_mem[0]) begin n_bad++; $display("FAIL gapped_read got %h want %h", rom_data_o, m_mem[0]); end
   endtask
   task automatic test_boundary();
      send_load(0, 0);
      rom_addr_i = 0;
      #1;
      n_cmp++; if (ld_done_o !== 1'b1 || word_cnt_o !== 16'd0 || rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL zero_len got done=%b cnt=%0d data=%h want 1 0 0000", ld_done_o, word_cnt_o, rom_data_o); end
      send_load(DEPTH, 0);
      n_cmp++; if (word_cnt_o !== 16'(DEPTH) || err_o !== 1'b0) begin n_bad++; $display("FAIL full_cnt got cnt=%0d err=%b want %0d 0", word_cnt_o, err_o, DEPTH); end
      foreach (m_mem[a]) begin
         rom_addr_i = 16'(a);
         #1;
         n_cmp++; if (rom_data_o !== m_mem[a]) begin n_bad++; $display("FAIL full_read[%0d] got %h want %h", a, rom_data_o, m_mem[a]); end
      end
      rom_addr_i = 16'(DEPTH);
      #1;
      n_cmp++; if (rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL full_nowrap got %h want 0000", rom_data_o); end
      send_load($urandom_range(DEPTH + 1, 65535), 0);
      n_cmp++; if (err_o !== 1'b1 || cpu_rst_o !== 1'b1) begin n_bad++; $display("FAIL over_len got err=%b cpu_rst=%b want 1 1", err_o, cpu_rst_o); end
   endtask
   task automatic test_random();
      repeat (8) begin
         send_load($urandom_range(0, 40), 1'($urandom));
         n_cmp++; if (ld_done_o !== m_run || word_cnt_o !== 16'(m_cnt)) begin n_bad++; $display("FAIL rand_state got done=%b cnt=%0d want %b %0d", ld_done_o, word_cnt_o, m_run, m_cnt); end
         for (int k = 0; k < m_cnt + 6; k++) begin
            int a;
            logic [15:0] exp;
            a = k < m_cnt + 2 ? k : $urandom_range(0, 65535);
            rom_addr_i = 16'(a);
            #1;
            exp = 16'h0000;
            if (a < m_cnt) exp = m_mem[a];
            n_cmp++; if (rom_data_o !== exp) begin n_bad++; $display("FAIL rand_read[%0d] got %h want %h", a, rom_data_o, exp); end
         end
      end
   endtask
   task automatic test_async_rst();
      send_load(3, 0);
      rom_addr_i = 0;
      #1;
      n_cmp++; if (rom_data_o !== m_mem[0]) begin n_bad++; $display("FAIL arst_pre got %h want %h", rom_data_o, m_mem[0]); end
      @(posedge clk);
      #3;
      rst = 1;
      #1;
      n_cmp++; if (cpu_rst_o !== 1'b1 || ld_done_o !== 1'b0) begin n_bad++; $display("FAIL arst_cpu got cpu_rst=%b done=%b want 1 0", cpu_rst_o, ld_done_o); end
      n_cmp++; if (rom_data_o !== 16'h0000 || word_cnt_o !== 16'd0) begin n_bad++; $display("FAIL arst_data got data=%h cnt=%0d want 0000 0", rom_data_o, word_cnt_o); end
      repeat (2) step();
      rst = 0;
      step();
      n_cmp++; if (cpu_rst_o !== 1'b1 || rom_data_o !== 16'h0000) begin n_bad++; $display("FAIL arst_after got cpu_rst=%b data=%h want 1 0000", cpu_rst_o, rom_data_o); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_err();
      test_restart();
      test_gapped();
      test_boundary();
      test_random();
      test_async_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
